// File: rtl/preg_scoreboard.sv
// Physical-register producer scoreboard: tracks in-flight writes from issue to
// write-back and stalls decode while a source's producer cannot be bypassed yet.
module preg_scoreboard #(
  parameter int PREG_ADDR_WIDTH = 6,
  parameter int CNT_WIDTH       = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_rs_enable,
  input  logic [PREG_ADDR_WIDTH-1:0] dec_prs_addr,
  input  logic                       dec_rt_enable,
  input  logic [PREG_ADDR_WIDTH-1:0] dec_prt_addr,
  input  logic                       issue_valid,
  input  logic                       issue_wb_reg,
  input  logic [PREG_ADDR_WIDTH-1:0] issue_write_addr,
  input  logic [1:0]                 issue_class,
  input  logic                       pipe_advance,
  input  logic                       muldiv_done,
  input  logic [PREG_ADDR_WIDTH-1:0] muldiv_addr,
  input  logic                       wb_wb_reg,
  input  logic [PREG_ADDR_WIDTH-1:0] wb_write_addr,
  input  logic                       flush,
  output logic                       dec_stall,
  output logic                       dec_rs_pending,
  output logic                       dec_rt_pending,
  output logic [CNT_WIDTH-1:0]       busy_count
);

  localparam int NUM_PREGS = 2 ** PREG_ADDR_WIDTH;
  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_MULDIV = 2'd2;
  localparam logic [1:0] AGE_WB     = 2'd2;

  logic [NUM_PREGS-1:0]      busy_q, busy_d;
  logic [NUM_PREGS-1:0]      ready_q, ready_d;
  logic [NUM_PREGS-1:0][1:0] cls_q, cls_d;
  logic [NUM_PREGS-1:0][1:0] age_q, age_d;
  logic [CNT_WIDTH-1:0]      busy_count_q, busy_count_d;

  logic                 issue_hit;
  logic                 clear_hit;
  logic                 count_inc;
  logic                 count_dec;
  logic [NUM_PREGS-1:0] fwd;

  assign issue_hit = issue_valid && issue_wb_reg && (issue_write_addr != '0);
  assign clear_hit = wb_wb_reg && busy_q[wb_write_addr];
  assign count_inc = issue_hit && !busy_q[issue_write_addr];
  assign count_dec = clear_hit && !(issue_hit && (issue_write_addr == wb_write_addr));

  // Reserved class 3 falls into the default arm and behaves as a load.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      case (cls_q[i])
        CLS_ALU:    fwd[i] = 1'b1;
        CLS_MULDIV: fwd[i] = ready_q[i];
        default:    fwd[i] = (age_q[i] != 2'd0);
      endcase
    end
  end

  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    cls_d        = cls_q;
    age_d        = age_q;
    busy_count_d = busy_count_q;

    for (int i = 0; i < NUM_PREGS; i++) begin
      if (pipe_advance && busy_q[i] && (cls_q[i] != CLS_MULDIV) && (age_q[i] != AGE_WB))
        age_d[i] = age_q[i] + 2'd1;
    end

    if (muldiv_done && busy_q[muldiv_addr] && (cls_q[muldiv_addr] == CLS_MULDIV))
      ready_d[muldiv_addr] = 1'b1;

    if (clear_hit)
      busy_d[wb_write_addr] = 1'b0;

    // Issue is applied last so it overrides a same-cycle clear, advance or completion.
    if (issue_hit) begin
      busy_d[issue_write_addr]  = 1'b1;
      cls_d[issue_write_addr]   = issue_class;
      age_d[issue_write_addr]   = 2'd0;
      ready_d[issue_write_addr] = 1'b0;
    end

    if (count_inc && !count_dec)
      busy_count_d = busy_count_q + CNT_WIDTH'(1);
    else if (count_dec && !count_inc)
      busy_count_d = busy_count_q - CNT_WIDTH'(1);

    if (flush) begin
      busy_d       = '0;
      ready_d      = '0;
      busy_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      ready_q      <= '0;
      cls_q        <= '0;
      age_q        <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      cls_q        <= cls_d;
      age_q        <= age_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign dec_rs_pending = dec_rs_enable && (dec_prs_addr != '0) &&
                          busy_q[dec_prs_addr] && !fwd[dec_prs_addr];
  assign dec_rt_pending = dec_rt_enable && (dec_prt_addr != '0) &&
                          busy_q[dec_prt_addr] && !fwd[dec_prt_addr];
  assign dec_stall      = dec_rs_pending || dec_rt_pending;
  assign busy_count     = busy_count_q;

endmodule

// File: tb/tb_preg_scoreboard.sv
// Directed bench for preg_scoreboard with a per-register reference model and
// a negedge compare of every hazard output and the busy count.
module tb_preg_scoreboard;

  localparam int AW = 6;
  localparam int NP = 64;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_rs_enable, dec_rt_enable;
  logic [AW-1:0] dec_prs_addr, dec_prt_addr;
  logic          issue_valid, issue_wb_reg;
  logic [AW-1:0] issue_write_addr;
  logic [1:0]    issue_class;
  logic          pipe_advance, muldiv_done, wb_wb_reg, flush;
  logic [AW-1:0] muldiv_addr, wb_write_addr;
  logic          dec_stall, dec_rs_pending, dec_rt_pending;
  logic [CW-1:0] busy_count;

  preg_scoreboard #(.PREG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_rs_enable(dec_rs_enable), .dec_prs_addr(dec_prs_addr),
    .dec_rt_enable(dec_rt_enable), .dec_prt_addr(dec_prt_addr),
    .issue_valid(issue_valid), .issue_wb_reg(issue_wb_reg),
    .issue_write_addr(issue_write_addr), .issue_class(issue_class),
    .pipe_advance(pipe_advance), .muldiv_done(muldiv_done), .muldiv_addr(muldiv_addr),
    .wb_wb_reg(wb_wb_reg), .wb_write_addr(wb_write_addr), .flush(flush),
    .dec_stall(dec_stall), .dec_rs_pending(dec_rs_pending),
    .dec_rt_pending(dec_rt_pending), .busy_count(busy_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each register remembers who produces it, how many pipeline moves it has
  // seen since issue, and whether a mul/div result has arrived.
  bit m_busy  [NP];
  int m_cls   [NP];
  int m_moves [NP];
  bit m_ready [NP];
  bit model_ok = 1'b0;

  function automatic bit m_bypassable(input int a);
    if (m_cls[a] == 0) return 1'b1;
    if (m_cls[a] == 2) return m_ready[a];
    return m_moves[a] >= 1;
  endfunction

  function automatic bit m_pending(input bit en, input int a);
    return en && a != 0 && m_busy[a] && !m_bypassable(a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NP; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit m_stall();
    return m_pending(dec_rs_enable, int'(dec_prs_addr)) ||
           m_pending(dec_rt_enable, int'(dec_prt_addr));
  endfunction

  task automatic model_update();
    bit old_busy [NP];
    int old_cls  [NP];
    if (rst || flush) begin
      for (int i = 0; i < NP; i++) begin m_busy[i] = 0; m_ready[i] = 0; end
      if (rst) model_ok = 1'b1;
      return;
    end
    old_busy = m_busy;
    old_cls  = m_cls;
    for (int i = 0; i < NP; i++)
      if (pipe_advance && old_busy[i] && old_cls[i] != 2)
        m_moves[i] = (m_moves[i] >= 2) ? 2 : m_moves[i] + 1;
    if (muldiv_done && old_busy[muldiv_addr] && old_cls[muldiv_addr] == 2)
      m_ready[muldiv_addr] = 1;
    if (wb_wb_reg) m_busy[wb_write_addr] = 0;
    if (issue_valid && issue_wb_reg && issue_write_addr != 0) begin
      m_busy[issue_write_addr]  = 1;
      m_cls[issue_write_addr]   = int'(issue_class);
      m_moves[issue_write_addr] = 0;
      m_ready[issue_write_addr] = 0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_ok && !rst) begin
      chk("rs_pending", 32'(dec_rs_pending), 32'(m_pending(dec_rs_enable, int'(dec_prs_addr))));
      chk("rt_pending", 32'(dec_rt_pending), 32'(m_pending(dec_rt_enable, int'(dec_prt_addr))));
      chk("stall", 32'(dec_stall), 32'(m_stall()));
      chk("busy_count", 32'(busy_count), 32'(m_count()));
      chk("no_issue_under_stall", 32'(issue_valid && dec_stall), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; dec_rs_enable = 0; dec_prs_addr = '0; dec_rt_enable = 0; dec_prt_addr = '0;
    issue_valid = 0; issue_wb_reg = 0; issue_write_addr = '0; issue_class = '0;
    pipe_advance = 0; muldiv_done = 0; muldiv_addr = '0;
    wb_wb_reg = 0; wb_write_addr = '0; flush = 0;
  endtask

  task automatic set_issue(input bit v, input int a, input int c);
    issue_valid = v; issue_wb_reg = v;
    issue_write_addr = AW'(a); issue_class = 2'(c);
  endtask

  task automatic set_dec(input bit rs_en, input int rs, input bit rt_en, input int rt);
    dec_rs_enable = rs_en; dec_prs_addr = AW'(rs);
    dec_rt_enable = rt_en; dec_prt_addr = AW'(rt);
  endtask

  task automatic issue1(input int a, input int c);
    set_issue(1, a, c); step(); set_issue(0, 0, 0);
  endtask

  task automatic wb1(input int a);
    wb_wb_reg = 1; wb_write_addr = AW'(a); step(); wb_wb_reg = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;

    // reset state
    set_dec(1, 5, 0, 0); #1;
    chk("lit_reset_stall", 32'(dec_stall), 0);
    chk("lit_reset_count", 32'(busy_count), 0);

    // three loads in flight, then reset over a concurrent issue
    set_dec(0, 0, 0, 0);
    issue1(1, 1); issue1(2, 1); issue1(3, 1);
    set_dec(1, 3, 1, 2); #1;
    chk("lit_pre_rst_count", 32'(busy_count), 3);
    chk("lit_pre_rst_stall", 32'(dec_stall), 1);
    rst = 1; set_issue(1, 4, 0); step(); rst = 0; set_issue(0, 0, 0); #1;
    chk("lit_post_rst_count", 32'(busy_count), 0);
    chk("lit_post_rst_stall", 32'(dec_stall), 0);
    chk("lit_post_rst_rs", 32'(dec_rs_pending), 0);
    chk("lit_post_rst_rt", 32'(dec_rt_pending), 0);

    // load-use: stall until the load reaches mem
    set_dec(0, 0, 0, 0);
    issue1(7, 1);
    set_dec(1, 7, 0, 0); #1;
    chk("lit_load_stall", 32'(dec_stall), 1);
    chk("lit_load_rs_pend", 32'(dec_rs_pending), 1);
    chk("lit_load_rt_pend", 32'(dec_rt_pending), 0);
    step();
    chk("lit_load_hold", 32'(dec_stall), 1);
    pipe_advance = 1; step(); pipe_advance = 0; #1;
    chk("lit_load_fwd", 32'(dec_stall), 0);
    wb1(7); #1;
    chk("lit_load_cleared", 32'(busy_count), 0);

    // ALU producer is bypassable immediately
    set_dec(0, 0, 0, 0);
    issue1(9, 0);
    set_dec(0, 0, 1, 9); #1;
    chk("lit_alu_stall", 32'(dec_stall), 0);
    chk("lit_alu_count", 32'(busy_count), 1);
    wb1(9); #1;
    chk("lit_alu_clear", 32'(busy_count), 0);

    // mul/div waits for completion regardless of pipeline movement
    set_dec(0, 0, 0, 0);
    issue1(12, 2);
    pipe_advance = 1; repeat (4) step(); pipe_advance = 0;
    set_dec(1, 12, 0, 0); #1;
    chk("lit_md_stall", 32'(dec_stall), 1);
    muldiv_done = 1; muldiv_addr = AW'(13); step();
    chk("lit_md_wrong_addr", 32'(dec_stall), 1);
    chk("lit_md_wrong_cnt", 32'(busy_count), 1);
    muldiv_addr = AW'(12); step(); muldiv_done = 0; #1;
    chk("lit_md_done", 32'(dec_stall), 0);

    // same-cycle reissue and clear of p20
    set_dec(0, 0, 0, 0);
    issue1(20, 0);
    set_issue(1, 20, 1); wb_wb_reg = 1; wb_write_addr = AW'(20); step();
    set_issue(0, 0, 0); wb_wb_reg = 0;
    set_dec(1, 20, 0, 0); #1;
    chk("lit_reissue_count", 32'(busy_count), 2);
    chk("lit_reissue_stall", 32'(dec_stall), 1);
    set_dec(1, 0, 1, 0);
    issue1(0, 1); #1;
    chk("lit_p0_stall", 32'(dec_stall), 0);
    chk("lit_p0_count", 32'(busy_count), 2);
    set_dec(0, 0, 0, 0);
    issue1(12, 3);
    set_dec(0, 0, 1, 12); #1;
    chk("lit_waw_stall", 32'(dec_stall), 1);
    chk("lit_waw_count", 32'(busy_count), 2);
    set_dec(0, 0, 0, 0);
    set_issue(1, 30, 0); wb_wb_reg = 1; wb_write_addr = AW'(20); step();
    set_issue(0, 0, 0); wb_wb_reg = 0; #1;
    chk("lit_net_zero", 32'(busy_count), 2);

    // flush
    for (int i = 40; i < 50; i++) issue1(i, 0);
    chk("lit_fill12", 32'(busy_count), 12);
    flush = 1; step(); #1;
    chk("lit_flush", 32'(busy_count), 0);
    set_issue(1, 50, 0); step(); flush = 0; set_issue(0, 0, 0); #1;
    chk("lit_flush_issue", 32'(busy_count), 0);

    // every trackable register busy
    for (int i = 1; i < NP; i++) issue1(i, 0);
    chk("lit_full", 32'(busy_count), 63);
    issue1(5, 1); #1;
    chk("lit_full_waw", 32'(busy_count), 63);

    // mixed traffic; issue only when the model says decode may proceed
    rst = 1; step(); rst = 0;
    for (int n = 0; n < 400; n++) begin
      set_dec(1'($urandom_range(0, 1)), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), $urandom_range(0, 15));
      pipe_advance  = 1'($urandom_range(0, 1));
      muldiv_done   = ($urandom_range(0, 3) == 0);
      muldiv_addr   = AW'($urandom_range(0, 15));
      wb_wb_reg     = ($urandom_range(0, 2) == 0);
      wb_write_addr = AW'($urandom_range(0, 15));
      flush         = ($urandom_range(0, 60) == 0);
      set_issue(!m_stall() && $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                $urandom_range(0, 3));
      step();
    end

    idle(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
